div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset as elsewhere in the CPU.
REQ-002 clk  input  1  rising-edge clock shared with the datapath.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 DivCtrl  input  1  start request, sampled only in IDLE.
REQ-005 A  input  32  dividend (register A output), two's complement.
REQ-006 B  input  32  divisor (register B output), two's complement.
REQ-007 DivHI  output  32  remainder, routed to the HI source mux.
REQ-008 DivLO  output  32  quotient, routed to the LO source mux.
REQ-009 DivDone  output  1  one-cycle pulse: DivHI/DivLO hold a new result.
REQ-010 DivZero  output  1  one-cycle pulse: divide-by-zero exception to control.
REQ-011 DivBusy  output  1  high while in any state other than IDLE.

Function
REQ-012 FSM states SHALL be IDLE, RUN and FIX.
- IDLE, DivCtrl=1, B!=0: capture |A|, |B| and both signs, clear the partial remainder, load the iteration counter with 32, go to RUN.
- IDLE, DivCtrl=1, B==0: stay in IDLE and pulse DivZero.
REQ-013 RUN SHALL perform one restoring step per cycle:
- shift {remainder, dividend} left by 1;
- trial-subtract |B| from the 33-bit remainder;
- keep the difference if it is non-negative, and set quotient bit = NOT borrow;
- decrement the counter; leave RUN after the 32nd step.
REQ-014 FIX SHALL apply the signs in one cycle:
- quotient is negated if sign(A) XOR sign(B);
- remainder is negated if sign(A);
- DivHI/DivLO are loaded, the FSM returns to IDLE, and DivDone is registered high for the following cycle.
REQ-015 Semantics SHALL match MIPS DIV: quotient truncated toward zero; remainder has the sign of the dividend; |remainder| < |divisor|.
REQ-016 The case 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0, with no flag raised (32-bit wrap).
REQ-017 Latency: if DivCtrl is sampled at edge E, DivDone SHALL be high during the cycle after edge E+34; DivBusy is high from edge E until edge E+34.
REQ-018 DivZero SHALL be high for exactly the cycle after the sampling edge, and DivHI/DivLO SHALL be left unchanged.
REQ-019 DivCtrl SHALL be ignored while DivBusy=1.
REQ-020 A DivCtrl during the DivDone cycle SHALL be accepted, because the FSM is already in IDLE.
REQ-021 Changes on A and B after the sampling edge SHALL NOT affect the result.
REQ-022 DivHI/DivLO SHALL hold their last value until the next FIX; DivDone and DivZero SHALL NOT be asserted together.

Reset
REQ-023 reset=1 at a rising edge SHALL force IDLE from any state, including mid-RUN, and abandon the operation.
REQ-024 On reset, DivHI, DivLO, DivDone, DivZero, DivBusy, the counter and all internal operand registers SHALL be 0.
REQ-025 reset SHALL take priority over a DivCtrl sampled at the same edge.

Structure
REQ-026 A shared CPU package SHALL hold the state encoding constants (IDLE/RUN/FIX), DIV_WIDTH=32 and DIV_ITER=32; the mult unit reuses the package.
REQ-027 One combinational sub-module, div_step (a single restoring step: shift, 33-bit subtract, quotient bit), SHALL be instantiated once inside RUN.

Verification
REQ-028 A=100, B=7 -> DivLO=0x0000000E, DivHI=0x00000002, DivDone in the cycle after edge E+34, one cycle wide.
REQ-029 A=-100, B=7 -> DivLO=0xFFFFFFF2, DivHI=0xFFFFFFFE; A=100, B=-7 -> DivLO=0xFFFFFFF2, DivHI=0x00000002.
REQ-030 A=0x80000000, B=0xFFFFFFFF -> DivLO=0x80000000, DivHI=0, DivZero=0.
REQ-031 Prior result 14/2 held, then A=5, B=0 -> DivZero=1 for one cycle, DivBusy=0, DivDone=0, DivHI/DivLO still 2/14.
REQ-032 reset pulsed 10 cycles into RUN -> all outputs 0 and IDLE next cycle, no DivDone; then 9/3 -> LO=3, HI=0.
REQ-033 DivCtrl held high mid-RUN with changed A/B -> result unaffected; back-to-back start in the DivDone cycle accepted, giving a second result 35 cycles later.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared CPU arithmetic package.
// Holds the iterative divider/multiplier FSM state encoding and operand
// sizing constants used by div_unit, div_step and the mult unit.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = 32;
  localparam int CNT_W     = $clog2(DIV_ITER + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step (purely combinational).
// Ports:
//   rem_in  : current 33-bit partial remainder
//   dvd_in  : dividend shift register; quotient bits enter at the LSB
//   dvs     : divisor magnitude
//   rem_out : partial remainder after shift and trial subtract
//   dvd_out : dividend shifted left with the new quotient bit appended
module div_step
  import div_unit_pkg::*;
(
  input  logic [DIV_WIDTH:0]   rem_in,
  input  logic [DIV_WIDTH-1:0] dvd_in,
  input  logic [DIV_WIDTH-1:0] dvs,
  output logic [DIV_WIDTH:0]   rem_out,
  output logic [DIV_WIDTH-1:0] dvd_out
);

  logic [DIV_WIDTH+1:0] shifted;
  logic [DIV_WIDTH+1:0] diff;
  logic                 borrow;
  // The partial remainder never reaches 2^32, so the top shifted bit is
  // always zero; it is kept only so the subtract has a clean borrow bit.
  logic                 unused_msb;

  always_comb begin
    shifted    = {rem_in, dvd_in[DIV_WIDTH-1]};
    diff       = shifted - {2'b00, dvs};
    borrow     = diff[DIV_WIDTH+1];
    rem_out    = borrow ? shifted[DIV_WIDTH:0] : diff[DIV_WIDTH:0];
    dvd_out    = {dvd_in[DIV_WIDTH-2:0], ~borrow};
    unused_msb = shifted[DIV_WIDTH+1];
  end

endmodule

// File: rtl/div_unit.sv
// Iterative signed 32-bit divider with MIPS DIV semantics.
// Magnitudes are divided with a restoring algorithm (one bit per cycle),
// then signs are applied: quotient truncates toward zero, remainder takes
// the dividend's sign.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   DivCtrl    : start request, sampled only in IDLE
//   A, B       : dividend / divisor, two's complement
//   DivHI      : remainder (held until the next result)
//   DivLO      : quotient  (held until the next result)
//   DivDone    : one-cycle pulse when DivHI/DivLO hold a new result
//   DivZero    : one-cycle pulse on a divide-by-zero request
//   DivBusy    : high in any state other than IDLE
module div_unit
  import div_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 DivCtrl,
  input  logic [DIV_WIDTH-1:0] A,
  input  logic [DIV_WIDTH-1:0] B,
  output logic [DIV_WIDTH-1:0] DivHI,
  output logic [DIV_WIDTH-1:0] DivLO,
  output logic                 DivDone,
  output logic                 DivZero,
  output logic                 DivBusy
);

  div_state_t           state, state_nxt;
  logic [DIV_WIDTH:0]   rem;
  logic [DIV_WIDTH-1:0] dvd;
  logic [DIV_WIDTH-1:0] dvs;
  logic                 sign_a, sign_b;
  logic [CNT_W-1:0]     cnt;

  logic [DIV_WIDTH:0]   step_rem;
  logic [DIV_WIDTH-1:0] step_dvd;

  // Magnitude of a two's-complement value; 0x80000000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [DIV_WIDTH-1:0] abs_val(input logic signed [DIV_WIDTH-1:0] v);
    return v[DIV_WIDTH-1] ? DIV_WIDTH'(-v) : DIV_WIDTH'(v);
  endfunction

  function automatic logic [DIV_WIDTH-1:0] cond_neg(input logic [DIV_WIDTH-1:0] v,
                                                    input logic neg);
    return neg ? DIV_WIDTH'(-v) : v;
  endfunction

  div_step u_div_step (
    .rem_in  (rem),
    .dvd_in  (dvd),
    .dvs     (dvs),
    .rem_out (step_rem),
    .dvd_out (step_dvd)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (DivCtrl && (B != '0)) state_nxt = RUN;
      // The counter reaching zero costs one extra RUN cycle, giving a
      // fixed 35-cycle start-to-start period.
      RUN:     if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rem     <= '0;
      dvd     <= '0;
      dvs     <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      cnt     <= '0;
      DivHI   <= '0;
      DivLO   <= '0;
      DivDone <= 1'b0;
      DivZero <= 1'b0;
    end else begin
      state   <= state_nxt;
      DivDone <= 1'b0;
      DivZero <= 1'b0;
      case (state)
        IDLE: begin
          if (DivCtrl) begin
            if (B == '0) begin
              DivZero <= 1'b1;
            end else begin
              rem    <= '0;
              dvd    <= abs_val(A);
              dvs    <= abs_val(B);
              sign_a <= A[DIV_WIDTH-1];
              sign_b <= B[DIV_WIDTH-1];
              cnt    <= CNT_W'(DIV_ITER);
            end
          end
        end
        RUN: begin
          if (cnt != '0) begin
            rem <= step_rem;
            dvd <= step_dvd;
            cnt <= cnt - 1'b1;
          end
        end
        FIX: begin
          DivLO   <= cond_neg(dvd, sign_a ^ sign_b);
          DivHI   <= cond_neg(rem[DIV_WIDTH-1:0], sign_a);
          DivDone <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign DivBusy = (state != IDLE);

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        DivCtrl;
  logic [31:0] A, B;
  logic [31:0] DivHI, DivLO;
  logic        DivDone, DivZero, DivBusy;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi, exp_lo;

  div_unit dut (
    .clk     (clk),
    .reset   (reset),
    .DivCtrl (DivCtrl),
    .A       (A),
    .B       (B),
    .DivHI   (DivHI),
    .DivLO   (DivLO),
    .DivDone (DivDone),
    .DivZero (DivZero),
    .DivBusy (DivBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // MIPS DIV reference: signed division truncating toward zero, done in
  // 64 bits so the INT_MIN / -1 case simply wraps when cut to 32 bits.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lq = sa / sb;
    lr = sa - lq * sb;
    q  = lq[31:0];
    r  = lr[31:0];
  endfunction

  // Called on a negedge; raises DivCtrl for the next rising edge and
  // returns on the negedge right after it.
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    A = a;
    B = b;
    DivCtrl = 1'b1;
    @(posedge clk);
    @(negedge clk);
    DivCtrl = 1'b0;
  endtask

  // Entered on the first negedge after the sampling edge (index 1).
  // DivDone must be first seen at index 35. Returns on the DivDone negedge.
  task automatic wait_done(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input bit disturb);
    int idx;
    logic [31:0] q, r;
    model(a, b, q, r);
    idx = 1;
    chk({tag, "_busy_start"}, 32'(DivBusy), 32'd1);
    while (!DivDone && idx < 60) begin
      if (disturb) begin
        if (idx >= 2 && idx <= 30) begin
          A = $urandom;
          B = $urandom;
          DivCtrl = 1'b1;
        end else begin
          DivCtrl = 1'b0;
        end
      end
      if (idx == 34) chk({tag, "_busy_last"}, 32'(DivBusy), 32'd1);
      @(negedge clk);
      idx++;
    end
    chk({tag, "_latency"}, 32'(idx), 32'd35);
    chk({tag, "_lo"}, DivLO, q);
    chk({tag, "_hi"}, DivHI, r);
    chk({tag, "_busy_end"}, 32'(DivBusy), 32'd0);
    chk({tag, "_zero_flag"}, 32'(DivZero), 32'd0);
    exp_lo = q;
    exp_hi = r;
  endtask

  task automatic done_width(input string tag);
    @(negedge clk);
    chk({tag, "_done_width"}, 32'(DivDone), 32'd0);
    chk({tag, "_lo_hold"}, DivLO, exp_lo);
    chk({tag, "_hi_hold"}, DivHI, exp_hi);
  endtask

  task automatic full_div(input string tag, input logic [31:0] a, input logic [31:0] b);
    start(a, b);
    wait_done(tag, a, b, 1'b0);
    done_width(tag);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit done_seen;

    reset = 1'b1;
    DivCtrl = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_hi", DivHI, 32'd0);
    chk("rst_lo", DivLO, 32'd0);
    chk("rst_done", 32'(DivDone), 32'd0);
    chk("rst_zero", 32'(DivZero), 32'd0);
    chk("rst_busy", 32'(DivBusy), 32'd0);
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);

    full_div("d100_7", 32'd100, 32'd7);
    chk("d100_7_lo_const", DivLO, 32'h0000000E);
    chk("d100_7_hi_const", DivHI, 32'h00000002);

    // Divide by zero: flag only, results untouched.
    start(32'd5, 32'd0);
    chk("dz_zero", 32'(DivZero), 32'd1);
    chk("dz_busy", 32'(DivBusy), 32'd0);
    chk("dz_done", 32'(DivDone), 32'd0);
    chk("dz_hi", DivHI, 32'h00000002);
    chk("dz_lo", DivLO, 32'h0000000E);
    @(negedge clk);
    chk("dz_zero_width", 32'(DivZero), 32'd0);
    chk("dz_busy_after", 32'(DivBusy), 32'd0);

    full_div("dm100_7", 32'hFFFFFF9C, 32'd7);
    chk("dm100_7_lo_const", DivLO, 32'hFFFFFFF2);
    chk("dm100_7_hi_const", DivHI, 32'hFFFFFFFE);
    full_div("d100_m7", 32'd100, 32'hFFFFFFF9);
    chk("d100_m7_lo_const", DivLO, 32'hFFFFFFF2);
    chk("d100_m7_hi_const", DivHI, 32'h00000002);
    full_div("intmin_m1", 32'h80000000, 32'hFFFFFFFF);
    chk("intmin_m1_lo_const", DivLO, 32'h80000000);
    chk("intmin_m1_hi_const", DivHI, 32'h00000000);
    full_div("intmin_1", 32'h80000000, 32'd1);
    full_div("small_big", 32'd3, 32'h80000000);
    full_div("max_max", 32'h7FFFFFFF, 32'h7FFFFFFF);

    // Reset in the middle of RUN, with DivCtrl asserted at the same edge.
    start(32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    DivCtrl = 1'b1;
    A = 32'd77;
    B = 32'd5;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    DivCtrl = 1'b0;
    chk("midrst_hi", DivHI, 32'd0);
    chk("midrst_lo", DivLO, 32'd0);
    chk("midrst_busy", 32'(DivBusy), 32'd0);
    chk("midrst_done", 32'(DivDone), 32'd0);
    chk("midrst_zero", 32'(DivZero), 32'd0);
    exp_hi = '0;
    exp_lo = '0;
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (DivDone || DivBusy) done_seen = 1'b1;
    end
    chk("midrst_no_done", 32'(done_seen), 32'd0);
    full_div("d9_3", 32'd9, 32'd3);

    // Inputs and DivCtrl wiggled during RUN, then a back-to-back start
    // issued in the DivDone cycle.
    start(32'd12345, 32'hFFFFFF85);
    wait_done("disturb", 32'd12345, 32'hFFFFFF85, 1'b1);
    start(32'hDEADBEEF, 32'd1234);
    chk("b2b_done_width", 32'(DivDone), 32'd0);
    wait_done("b2b", 32'hDEADBEEF, 32'd1234, 1'b0);
    done_width("b2b");

    // Random operands, with occasional small divisors.
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($signed(5'($urandom)))
                        : 32'($urandom);
      if (rb == '0) rb = 32'd1;
      full_div("rand", ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
